// File: rtl/cdb_pkg.sv
// Shared definitions for the CDB arbiter slice.
// Contents: source IDs, default tag width, result payload words,
// and a mod-3 adder used by the round-robin pointer.
package cdb_pkg;

  localparam int unsigned ENTRY_W_DEF = 4;
  localparam int unsigned N_SRC       = 3;

  localparam logic [1:0] SRC_ALU = 2'd0;
  localparam logic [1:0] SRC_LD  = 2'd1;
  localparam logic [1:0] SRC_ST  = 2'd2;

  // Payload words of one result. The ROB tag travels beside this struct
  // so that its width can remain a module parameter.
  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] d2;
  } cdb_payload_t;

  // (a + b) mod 3 for operands in 0..2.
  function automatic logic [1:0] src_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer and CDB bus bundle of the CDB arbiter.
// slave  : arbiter side (takes producer pulses, drives CDB/stall/ovf).
// master : environment side (drives producer pulses, observes CDB).
interface cdb_arbiter_if #(
  parameter int unsigned ENTRY_W = cdb_pkg::ENTRY_W_DEF
);

  logic               alu_valid;
  logic [ENTRY_W-1:0] alu_entry;
  logic [31:0]        alu_result;
  logic [31:0]        alu_pc;
  logic [31:0]        alu_pc_init;

  logic               ld_valid;
  logic [ENTRY_W-1:0] ld_entry;
  logic [31:0]        ld_result;

  logic               st_valid;
  logic [ENTRY_W-1:0] st_entry;
  logic [31:0]        st_addr;
  logic [31:0]        st_data;

  logic               cdb_valid;
  logic [1:0]         cdb_src;
  logic [ENTRY_W-1:0] cdb_entry;
  logic [31:0]        cdb_d0;
  logic [31:0]        cdb_d1;
  logic [31:0]        cdb_d2;
  logic               cdb_stall;
  logic               ovf_err;

  modport slave (
    input  alu_valid, alu_entry, alu_result, alu_pc, alu_pc_init,
    input  ld_valid, ld_entry, ld_result,
    input  st_valid, st_entry, st_addr, st_data,
    output cdb_valid, cdb_src, cdb_entry, cdb_d0, cdb_d1, cdb_d2,
    output cdb_stall, ovf_err
  );

  modport master (
    output alu_valid, alu_entry, alu_result, alu_pc, alu_pc_init,
    output ld_valid, ld_entry, ld_result,
    output st_valid, st_entry, st_addr, st_data,
    input  cdb_valid, cdb_src, cdb_entry, cdb_d0, cdb_d1, cdb_d2,
    input  cdb_stall, ovf_err
  );

endinterface

// File: rtl/cdb_fifo.sv
// Per-source result FIFO with flush.
// Ports: clk, rst (sync active-low), i_en (freeze when low), i_flush,
//        i_push/i_entry/i_data (tail write), i_pop (head consume),
//        o_entry_c/o_data_c (head), o_full_c, o_empty_c,
//        o_count_nxt_c (occupancy after the coming edge).
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned ENTRY_W = ENTRY_W_DEF,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_en,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [ENTRY_W-1:0]     i_entry,
  input  cdb_payload_t           i_data,
  input  logic                   i_pop,
  output logic [ENTRY_W-1:0]     o_entry_c,
  output cdb_payload_t           o_data_c,
  output logic                   o_full_c,
  output logic                   o_empty_c,
  output logic [$clog2(DEPTH):0] o_count_nxt_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CNT_W-1:0]   r_count;
  logic [ENTRY_W-1:0] r_mem_entry [DEPTH];
  cdb_payload_t       r_mem_data  [DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full_c  = (r_count == CNT_W'(DEPTH));
  assign o_empty_c = (r_count == '0);

  // A full FIFO still accepts a push when its head leaves on the same edge.
  assign w_push = i_push && !i_flush && (!o_full_c || i_pop);
  assign w_pop  = i_pop && !o_empty_c && !i_flush;

  assign o_count_nxt_c = i_flush ? '0 : (r_count + CNT_W'(w_push) - CNT_W'(w_pop));

  assign o_entry_c = r_mem_entry[r_rd];
  assign o_data_c  = r_mem_data[r_rd];

  // Pointer and occupancy state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (i_flush) begin
        r_wr    <= '0;
        r_rd    <= '0;
        r_count <= '0;
      end else begin
        if (w_push) r_wr <= r_wr + PTR_W'(1);
        if (w_pop)  r_rd <= r_rd + PTR_W'(1);
        r_count <= o_count_nxt_c;
      end
    end
  end

  // Storage; contents are only meaningful below the count, so no reset.
  always_ff @(posedge clk) begin
    if (i_en && w_push) begin
      r_mem_entry[r_wr] <= i_entry;
      r_mem_data[r_wr]  <= i_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU / load / store result pulses in
// per-source FIFOs and grants one per cycle round-robin onto a registered CDB.
// Ports: clk, rst (sync active-low), rdy (global freeze when low),
//        rollback (flush), bus (cdb_arbiter_if.slave: producer pulses in,
//        CDB payload, cdb_stall and sticky ovf_err out).
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned ENTRY_W = ENTRY_W_DEF,
  parameter int unsigned DEPTH   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         rollback,
  cdb_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [N_SRC-1:0]   w_valid;
  logic [N_SRC-1:0]   w_full;
  logic [N_SRC-1:0]   w_empty;
  logic [N_SRC-1:0]   w_pop;
  logic [ENTRY_W-1:0] w_in_entry   [N_SRC];
  cdb_payload_t       w_in_data    [N_SRC];
  logic [ENTRY_W-1:0] w_head_entry [N_SRC];
  cdb_payload_t       w_head_data  [N_SRC];
  logic [CNT_W-1:0]   w_cnt_nxt    [N_SRC];

  logic               w_gnt_valid;
  logic [1:0]         w_gnt_src;
  logic [1:0]         w_cand;
  logic               w_stall_nxt;
  logic               w_ovf;

  logic               r_valid;
  logic [1:0]         r_src;
  logic [ENTRY_W-1:0] r_entry;
  cdb_payload_t       r_data;
  logic               r_stall;
  logic               r_ovf;
  logic [1:0]         r_rr;

  // Producer payload mapping; unused words are stored as zero.
  assign w_valid = {bus.st_valid, bus.ld_valid, bus.alu_valid};
  assign w_in_entry[SRC_ALU] = bus.alu_entry;
  assign w_in_entry[SRC_LD]  = bus.ld_entry;
  assign w_in_entry[SRC_ST]  = bus.st_entry;
  assign w_in_data[SRC_ALU]  = {bus.alu_result, bus.alu_pc, bus.alu_pc_init};
  assign w_in_data[SRC_LD]   = {bus.ld_result, 32'd0, 32'd0};
  assign w_in_data[SRC_ST]   = {bus.st_addr, bus.st_data, 32'd0};

  for (genvar i = 0; i < N_SRC; i++) begin : g_fifo
    cdb_fifo #(
      .ENTRY_W (ENTRY_W),
      .DEPTH   (DEPTH)
    ) u_fifo (
      .clk           (clk),
      .rst           (rst),
      .i_en          (rdy),
      .i_flush       (rollback),
      .i_push        (w_valid[i]),
      .i_entry       (w_in_entry[i]),
      .i_data        (w_in_data[i]),
      .i_pop         (w_pop[i]),
      .o_entry_c     (w_head_entry[i]),
      .o_data_c      (w_head_data[i]),
      .o_full_c      (w_full[i]),
      .o_empty_c     (w_empty[i]),
      .o_count_nxt_c (w_cnt_nxt[i])
    );
  end

  // Round-robin pick: first non-empty source in order rr, rr+1, rr+2 (mod 3).
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt_src   = r_rr;
    w_cand      = r_rr;
    w_pop       = '0;
    for (int k = 0; k < 3; k++) begin
      w_cand = src_add(r_rr, 2'(k));
      if (!w_gnt_valid && !w_empty[w_cand]) begin
        w_gnt_valid = 1'b1;
        w_gnt_src   = w_cand;
      end
    end
    if (w_gnt_valid && !rollback) w_pop[w_gnt_src] = 1'b1;
  end

  // Stall looks at occupancy after this edge, leaving one slot of slack.
  always_comb begin
    w_stall_nxt = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (w_cnt_nxt[i] >= CNT_W'(DEPTH - 1)) w_stall_nxt = 1'b1;
    end
  end

  // A push is lost only when its FIFO is full and its head is not leaving.
  assign w_ovf = !rollback && |(w_valid & w_full & ~w_pop);

  // CDB output register, rotating pointer, stall and sticky overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_src   <= '0;
      r_entry <= '0;
      r_data  <= '0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
      r_rr    <= '0;
    end else if (rdy) begin
      if (w_ovf) r_ovf <= 1'b1;
      if (rollback) begin
        r_valid <= 1'b0;
        r_stall <= 1'b0;
      end else begin
        r_valid <= w_gnt_valid;
        r_stall <= w_stall_nxt;
        if (w_gnt_valid) begin
          r_src   <= w_gnt_src;
          r_entry <= w_head_entry[w_gnt_src];
          r_data  <= w_head_data[w_gnt_src];
          r_rr    <= src_add(w_gnt_src, 2'd1);
        end
      end
    end
  end

  assign bus.cdb_valid = r_valid;
  assign bus.cdb_src   = r_src;
  assign bus.cdb_entry = r_entry;
  assign bus.cdb_d0    = r_data.d0;
  assign bus.cdb_d1    = r_data.d1;
  assign bus.cdb_d2    = r_data.d2;
  assign bus.cdb_stall = r_stall;
  assign bus.ovf_err   = r_ovf;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus a randomized
// run, compared each cycle against a queue-based model of the arbiter rules.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int EW    = 4;
  localparam int DEPTH = 4;
  localparam int VW    = 1 + 2 + EW + 96 + 2;

  logic clk;
  logic rst;
  logic rdy;
  logic rollback;

  cdb_arbiter_if #(.ENTRY_W(EW)) bus();

  cdb_arbiter #(.ENTRY_W(EW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [EW-1:0] entry;
    logic [31:0]   d0;
    logic [31:0]   d1;
    logic [31:0]   d2;
  } item_t;

  // Reference model state
  item_t      qa[$];
  item_t      ql[$];
  item_t      qs[$];
  int         m_rr;
  logic       m_valid;
  logic [1:0] m_src;
  item_t      m_out;
  logic       m_stall;
  logic       m_ovf;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int uid   = 0;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.cdb_valid, bus.cdb_src, bus.cdb_entry, bus.cdb_d0,
                    bus.cdb_d1, bus.cdb_d2, bus.cdb_stall, bus.ovf_err};

  function automatic logic [VW-1:0] exp_vec();
    return {m_valid, m_src, m_out.entry, m_out.d0, m_out.d1, m_out.d2, m_stall, m_ovf};
  endfunction

  function automatic int qsize(int s);
    case (s)
      0:       return qa.size();
      1:       return ql.size();
      default: return qs.size();
    endcase
  endfunction

  task automatic qpush(int s, item_t it);
    case (s)
      0:       qa.push_back(it);
      1:       ql.push_back(it);
      default: qs.push_back(it);
    endcase
  endtask

  task automatic qpop(int s, output item_t it);
    case (s)
      0:       it = qa.pop_front();
      1:       it = ql.pop_front();
      default: it = qs.pop_front();
    endcase
  endtask

  task automatic qclear();
    qa.delete();
    ql.delete();
    qs.delete();
  endtask

  // Advance model by one edge from the currently driven inputs, then clock.
  task automatic tick();
    int    sz[3];
    int    gs;
    int    s;
    item_t g;
    if (!rst) begin
      qclear();
      m_rr = 0; m_valid = 0; m_src = 0; m_stall = 0; m_ovf = 0;
      m_out = '{0, 0, 0, 0};
    end else if (rdy) begin
      if (rollback) begin
        qclear();
        m_valid = 0;
        m_stall = 0;
      end else begin
        for (int i = 0; i < 3; i++) sz[i] = qsize(i);
        gs = -1;
        for (int k = 0; k < 3; k++) begin
          s = (m_rr + k) % 3;
          if (gs < 0 && sz[s] > 0) gs = s;
        end
        if (gs >= 0) begin
          qpop(gs, g);
          m_out = g; m_src = 2'(gs); m_valid = 1; m_rr = (gs + 1) % 3;
        end else begin
          m_valid = 0;
        end
        if (bus.alu_valid) begin
          if (sz[0] < DEPTH || gs == 0)
            qpush(0, '{bus.alu_entry, bus.alu_result, bus.alu_pc, bus.alu_pc_init});
          else m_ovf = 1;
        end
        if (bus.ld_valid) begin
          if (sz[1] < DEPTH || gs == 1) qpush(1, '{bus.ld_entry, bus.ld_result, 32'd0, 32'd0});
          else m_ovf = 1;
        end
        if (bus.st_valid) begin
          if (sz[2] < DEPTH || gs == 2) qpush(2, '{bus.st_entry, bus.st_addr, bus.st_data, 32'd0});
          else m_ovf = 1;
        end
        m_stall = 0;
        for (int i = 0; i < 3; i++) if (qsize(i) >= DEPTH - 1) m_stall = 1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_idle();
    rst = 1; rdy = 1; rollback = 0;
    bus.alu_valid = 0; bus.ld_valid = 0; bus.st_valid = 0;
  endtask

  task automatic set_alu(int e);
    uid++;
    bus.alu_valid = 1; bus.alu_entry = EW'(e); bus.alu_result = 32'(uid);
    bus.alu_pc = $urandom; bus.alu_pc_init = $urandom;
  endtask

  task automatic set_ld(int e);
    uid++;
    bus.ld_valid = 1; bus.ld_entry = EW'(e); bus.ld_result = 32'(uid) | 32'h1000_0000;
  endtask

  task automatic set_st(int e);
    uid++;
    bus.st_valid = 1; bus.st_entry = EW'(e); bus.st_addr = 32'(uid) | 32'h2000_0000;
    bus.st_data = $urandom;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 0; rdy = 0; rollback = 1;
    set_alu(1); set_ld(2); set_st(3);
    tick();
    n_cmp++;
    if (dut_vec !== '0) begin
      n_bad++; $display("FAIL reset_zero: got %h, want 0", dut_vec);
    end
    set_idle();
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL reset_idle cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
    end
  endtask

  task automatic test_single_alu();
    logic [VW-1:0] want;
    do_reset();
    set_idle();
    tick();
    bus.alu_valid = 1; bus.alu_entry = 4'd3; bus.alu_result = 32'h55;
    bus.alu_pc = 32'h104; bus.alu_pc_init = 32'h100;
    tick();
    set_idle();
    n_cmp++;
    if (bus.cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_latency1: got valid %b, want 0", bus.cdb_valid);
    end
    tick();
    want = {1'b1, 2'd0, 4'd3, 32'h55, 32'h104, 32'h100, 1'b0, 1'b0};
    n_cmp++;
    if (dut_vec !== want) begin
      n_bad++; $display("FAIL single_result: got %h, want %h", dut_vec, want);
    end
    tick();
    n_cmp++;
    if (bus.cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_after: got valid %b, want 0", bus.cdb_valid);
    end
  endtask

  task automatic test_all_three();
    do_reset();
    set_alu(1); set_ld(2); set_st(3);
    tick();
    set_idle();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({bus.cdb_valid, bus.cdb_src, bus.cdb_entry} !== {1'b1, 2'(i), EW'(i + 1)}) begin
        n_bad++;
        $display("FAIL all3_order%0d: got v=%b src=%0d entry=%0d, want v=1 src=%0d entry=%0d",
                 i, bus.cdb_valid, bus.cdb_src, bus.cdb_entry, i, i + 1);
      end
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL all3_model cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
      tick();
    end
    n_cmp++;
    if (bus.cdb_valid !== 1'b0) begin
      n_bad++; $display("FAIL all3_drained: got valid %b, want 0", bus.cdb_valid);
    end
    // Pointer must have wrapped back to the ALU.
    set_alu(4); set_ld(5); set_st(6);
    tick();
    set_idle();
    tick();
    n_cmp++;
    if ({bus.cdb_valid, bus.cdb_src} !== {1'b1, SRC_ALU}) begin
      n_bad++; $display("FAIL all3_rr_wrap: got v=%b src=%0d, want v=1 src=0", bus.cdb_valid, bus.cdb_src);
    end
  endtask

  task automatic test_back_to_back();
    int ld_seen;
    bit stall_seen;
    ld_seen = -1;
    stall_seen = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      set_idle();
      set_alu(c); set_st(c);
      if (c == 0) set_ld(9);
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL b2b_model cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
      if (bus.cdb_valid === 1'b1 && bus.cdb_src === SRC_LD && ld_seen < 0) ld_seen = c;
      if (bus.cdb_stall === 1'b1) stall_seen = 1;
    end
    n_cmp++;
    if (ld_seen < 1 || ld_seen > 3) begin
      n_bad++; $display("FAIL b2b_ld_latency: got load at step %0d, want step 1..3", ld_seen);
    end
    n_cmp++;
    if (!stall_seen) begin
      n_bad++; $display("FAIL b2b_stall: got stall never set, want stall set");
    end
    set_idle();
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL b2b_drain cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_rollback();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      set_alu(c); set_ld(c); set_st(c);
      tick();
    end
    set_alu(7); set_ld(7); set_st(7);
    rollback = 1;
    tick();
    set_idle();
    n_cmp++;
    if ({bus.cdb_valid, bus.cdb_stall} !== 2'b00) begin
      n_bad++; $display("FAIL rollback_clear: got v=%b stall=%b, want v=0 stall=0", bus.cdb_valid, bus.cdb_stall);
    end
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL rollback_model cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_cmp++;
      if (bus.cdb_valid !== 1'b0) begin
        n_bad++; $display("FAIL rollback_empty step%0d: got valid %b src=%0d, want 0", c, bus.cdb_valid, bus.cdb_src);
      end
    end
  endtask

  task automatic test_full_fifo();
    do_reset();
    for (int c = 0; c < 14; c++) begin
      set_idle();
      set_alu(c); set_ld(c); set_st(c);
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL full_model cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
    end
    n_cmp++;
    if (bus.ovf_err !== 1'b1) begin
      n_bad++; $display("FAIL full_ovf: got ovf_err %b, want 1", bus.ovf_err);
    end
    set_idle();
    for (int c = 0; c < 14; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL full_drain cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_rdy_freeze();
    logic [VW-1:0] held;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      set_alu(c); set_ld(c); set_st(c);
      tick();
    end
    held = dut_vec;
    for (int c = 0; c < 3; c++) begin
      set_idle();
      rdy = 0;
      rollback = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) != 0) set_alu(c);
      if ($urandom_range(0, 1) != 0) set_st(c);
      tick();
      n_cmp++;
      if (dut_vec !== held) begin
        n_bad++; $display("FAIL freeze_hold step%0d: got %h, want %h", c, dut_vec, held);
      end
    end
    set_idle();
    for (int c = 0; c < 12; c++) begin
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL freeze_resume cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      set_alu(c); set_ld(c); set_st(c);
      tick();
    end
    rst = 0;
    tick();
    n_cmp++;
    if (dut_vec !== '0) begin
      n_bad++; $display("FAIL midreset_zero: got %h, want 0", dut_vec);
    end
    set_idle();
    tick();
    n_cmp++;
    if (dut_vec !== exp_vec()) begin
      n_bad++; $display("FAIL midreset_after cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_idle();
      rst      = ($urandom_range(0, 99) != 0);
      rdy      = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 1) != 0) set_alu($urandom_range(0, 15));
      if ($urandom_range(0, 2) != 0) set_ld($urandom_range(0, 15));
      if ($urandom_range(0, 1) != 0) set_st($urandom_range(0, 15));
      tick();
      n_cmp++;
      if (dut_vec !== exp_vec()) begin
        n_bad++; $display("FAIL random_model cyc=%0d: got %h, want %h", cyc, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    bus.alu_entry = '0; bus.alu_result = '0; bus.alu_pc = '0; bus.alu_pc_init = '0;
    bus.ld_entry = '0; bus.ld_result = '0;
    bus.st_entry = '0; bus.st_addr = '0; bus.st_data = '0;
    set_idle();
    test_reset();
    test_single_alu();
    test_all_three();
    test_back_to_back();
    test_rollback();
    test_full_fifo();
    test_rdy_freeze();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
